// File: rtl/leaf_nn_scanner.sv
// leaf_nn_scanner: scans every candidate patch in one leaf and returns the
// nearest one by squared L2 distance. The leaf memory is external and has a
// one-cycle synchronous read. The distance is computed over a two-stage
// pipeline (squares, then sum). A third stage compares the sum against the
// running minimum.
module leaf_nn_scanner #(
  parameter int DSIZE         = 11,
  parameter int NUM_DIMS      = 5,
  parameter int ADDRESS_WIDTH = 8,
  parameter int LEAF_SIZE     = 8,
  parameter int IDX_WIDTH     = 16,
  parameter int DIST_WIDTH    = 26
) (
  input  logic                                       clk,
  input  logic                                       rst,
  input  logic                                       in_valid,
  output logic                                       in_ready,
  input  logic [DSIZE*NUM_DIMS-1:0]                  patch_in,
  input  logic [ADDRESS_WIDTH-1:0]                   leaf_index,
  output logic                                       mem_ren,
  output logic [ADDRESS_WIDTH+$clog2(LEAF_SIZE)-1:0] mem_addr,
  input  logic [DSIZE*NUM_DIMS+IDX_WIDTH-1:0]        mem_rdata,
  output logic                                       out_valid,
  input  logic                                       out_ready,
  output logic [IDX_WIDTH-1:0]                       best_index,
  output logic [DIST_WIDTH-1:0]                      best_dist
);

  localparam int PATCH_WIDTH = DSIZE * NUM_DIMS;
  localparam int SLOT_W      = $clog2(LEAF_SIZE);
  localparam int DIFF_W      = DSIZE + 1;
  localparam int SQ_W        = 2 * DIFF_W;
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(LEAF_SIZE - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                     state_q, state_d;
  logic [SLOT_W-1:0]          slot_q, slot_d;
  logic [ADDRESS_WIDTH-1:0]   leaf_q, leaf_d;
  logic [PATCH_WIDTH-1:0]     query_q, query_d;
  logic                       accept;

  // Stage valid/last flags. A flag is set for a cycle that carries a real
  // candidate. The last flag marks the final slot of the leaf.
  logic                       rd_v_q, rd_last_q;
  logic                       sq_v_q, sq_last_q;
  logic                       sum_v_q, sum_last_q;

  // Stage 1: per-component squares, plus the index and empty flag of the candidate.
  logic [DIFF_W-1:0]          diff_c [NUM_DIMS];
  logic [DIFF_W-1:0]          mag_c  [NUM_DIMS];
  logic [SQ_W-1:0]            sq_d   [NUM_DIMS];
  logic [SQ_W-1:0]            sq_q   [NUM_DIMS];
  logic [IDX_WIDTH-1:0]       rd_idx, sq_idx_q;
  logic                       rd_empty, sq_empty_q;

  // Stage 2: summed distance.
  logic [DIST_WIDTH-1:0]      sum_d, sum_q;
  logic [IDX_WIDTH-1:0]       sum_idx_q;
  logic                       sum_empty_q;

  // Running best.
  logic [DIST_WIDTH-1:0]      best_dist_q, best_dist_d;
  logic [IDX_WIDTH-1:0]       best_idx_q, best_idx_d;

  // Next-state logic and outputs of the FSM.
  always_comb begin
    // NOTE: every variable driven here gets a default first, so no path leaves
    // one unassigned and no latch is inferred.
    state_d   = state_q;
    slot_d    = slot_q;
    leaf_d    = leaf_q;
    query_d   = query_q;
    in_ready  = 1'b0;
    mem_ren   = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = !rst;
        if (in_valid && !rst) begin
          accept  = 1'b1;
          query_d = patch_in;
          leaf_d  = leaf_index;
          slot_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        mem_ren = 1'b1;
        slot_d  = slot_q + SLOT_W'(1);
        if (slot_q == LAST_SLOT) state_d = DRAIN;
      end
      DRAIN: begin
        if (sum_v_q && sum_last_q) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // The address is driven only while a read is issued and sits at zero otherwise.
  assign mem_addr   = mem_ren ? {leaf_q, slot_q} : '0;
  assign best_index = best_idx_q;
  assign best_dist  = best_dist_q;

  // Stage 1 math: sign-extend both operands, subtract, take the magnitude, then square it.
  always_comb begin
    for (int i = 0; i < NUM_DIMS; i++) begin
      diff_c[i] = {mem_rdata[i*DSIZE+DSIZE-1], mem_rdata[i*DSIZE +: DSIZE]}
                - {query_q[i*DSIZE+DSIZE-1],   query_q[i*DSIZE +: DSIZE]};
      mag_c[i]  = diff_c[i][DIFF_W-1] ? -diff_c[i] : diff_c[i];
      sq_d[i]   = SQ_W'(mag_c[i]) * SQ_W'(mag_c[i]);
    end
  end

  assign rd_idx   = mem_rdata[PATCH_WIDTH +: IDX_WIDTH];
  assign rd_empty = &rd_idx;

  // Stage 2 math: DIST_WIDTH already holds NUM_DIMS full-scale squares.
  always_comb begin
    sum_d = '0;
    for (int i = 0; i < NUM_DIMS; i++) begin
      sum_d = sum_d + DIST_WIDTH'(sq_q[i]);
    end
  end

  // Stage 3: a strict less-than compare, so on a tie the earlier slot wins.
  // Empty slots never update the best.
  always_comb begin
    best_dist_d = best_dist_q;
    best_idx_d  = best_idx_q;
    if (accept) begin
      best_dist_d = '1;
      best_idx_d  = '1;
    end else if (sum_v_q && !sum_empty_q && (sum_q < best_dist_q)) begin
      best_dist_d = sum_q;
      best_idx_d  = sum_idx_q;
    end
  end

  // Control state, valid flags and the running best. Reset discards in-flight candidates.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments, so every register
    // samples its pre-edge value and ordering between blocks cannot matter.
    if (rst) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      leaf_q      <= '0;
      query_q     <= '0;
      rd_v_q      <= 1'b0;
      rd_last_q   <= 1'b0;
      sq_v_q      <= 1'b0;
      sq_last_q   <= 1'b0;
      sum_v_q     <= 1'b0;
      sum_last_q  <= 1'b0;
      best_dist_q <= '1;
      best_idx_q  <= '1;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      leaf_q      <= leaf_d;
      query_q     <= query_d;
      rd_v_q      <= mem_ren;
      rd_last_q   <= mem_ren && (slot_q == LAST_SLOT);
      sq_v_q      <= rd_v_q;
      sq_last_q   <= rd_last_q;
      sum_v_q     <= sq_v_q;
      sum_last_q  <= sq_last_q;
      best_dist_q <= best_dist_d;
      best_idx_q  <= best_idx_d;
    end
  end

  // Pipeline datapath registers.
  always_ff @(posedge clk) begin
    // NOTE: these data registers have no reset. The valid flags above decide
    // whether their contents are ever used, so stale data is harmless.
    sq_q        <= sq_d;
    sq_idx_q    <= rd_idx;
    sq_empty_q  <= rd_empty;
    sum_q       <= sum_d;
    sum_idx_q   <= sq_idx_q;
    sum_empty_q <= sq_empty_q;
  end

endmodule

// File: tb/tb_leaf_nn_scanner.sv
// Directed bench for leaf_nn_scanner. A behavioural memory answers reads.
// A nearest-neighbour model computes the expected result straight from the
// leaf contents. One compare process checks the outputs on every cycle of
// each tracked query.
module tb_leaf_nn_scanner;

  localparam int D    = 11;
  localparam int ND   = 5;
  localparam int LEAF = 8;
  localparam int PW   = D * ND;
  localparam int IW   = 16;
  localparam int DW   = 26;

  logic            clk = 1'b0;
  logic            rst;
  logic            in_valid;
  logic            in_ready;
  logic [PW-1:0]   patch_in;
  logic [7:0]      leaf_index;
  logic            mem_ren;
  logic [10:0]     mem_addr;
  logic [PW+IW-1:0] mem_rdata;
  logic            out_valid;
  logic            out_ready;
  logic [IW-1:0]   best_index;
  logic [DW-1:0]   best_dist;

  leaf_nn_scanner dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .patch_in   (patch_in),
    .leaf_index (leaf_index),
    .mem_ren    (mem_ren),
    .mem_addr   (mem_addr),
    .mem_rdata  (mem_rdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .best_index (best_index),
    .best_dist  (best_dist)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Leaf memory: the address is sampled while mem_ren is high, and the data
  // appears one cycle later. Garbage is returned when no read was issued.
  logic [PW+IW-1:0] mem [0:2047];
  logic             ren_s;
  logic [10:0]      addr_s;

  initial begin
    for (int i = 0; i < 2048; i++) mem[i] = '0;
    mem_rdata = '0;
    forever begin
      @(negedge clk);
      ren_s  = mem_ren;
      addr_s = mem_addr;
      @(posedge clk);
      #1;
      mem_rdata = ren_s ? mem[addr_s] : {$urandom, $urandom, $urandom};
    end
  end

  function automatic logic [PW-1:0] fill(input int v);
    logic [D-1:0] c;
    c = D'(v);
    return {ND{c}};
  endfunction

  task automatic put(input int leaf, input int s, input logic [IW-1:0] idx, input logic [PW-1:0] p);
    mem[leaf*LEAF + s] = {idx, p};
  endtask

  // Nearest-neighbour model: linear scan with a strict minimum, skipping empty slots.
  task automatic model(input logic [PW-1:0] q, input int leaf,
                       output logic [IW-1:0] bi, output logic [DW-1:0] bd);
    longint best;
    longint d;
    logic [PW+IW-1:0] e;
    logic signed [D-1:0] cc, qc;
    best = 64'h3FFFFFF;
    bi   = 16'hFFFF;
    for (int s = 0; s < LEAF; s++) begin
      e = mem[leaf*LEAF + s];
      if (e[PW +: IW] != 16'hFFFF) begin
        d = 0;
        for (int i = 0; i < ND; i++) begin
          cc = e[i*D +: D];
          qc = q[i*D +: D];
          d  = d + (longint'(cc) - longint'(qc)) * (longint'(cc) - longint'(qc));
        end
        if (d < best) begin
          best = d;
          bi   = e[PW +: IW];
        end
      end
    end
    bd = DW'(best);
  endtask

  // Expectations shared with the compare process.
  logic            track = 1'b0;
  int              exp_leaf;
  logic [IW-1:0]   exp_idx;
  logic [DW-1:0]   exp_dist;
  int              cyc = 0;

  // Per-cycle compare against the model. cyc counts cycles from the handshake (cycle 0).
  always @(negedge clk) begin
    if (!track) begin
      cyc = 0;
    end else begin
      if (cyc == 0) begin
        check("accept_in_ready", 64'(in_ready), 64'd1);
        check("accept_mem_ren", 64'(mem_ren), 64'd0);
      end else if (cyc <= LEAF) begin
        check($sformatf("fetch%0d_ren", cyc), 64'(mem_ren), 64'd1);
        check($sformatf("fetch%0d_addr", cyc), 64'(mem_addr), 64'(exp_leaf*LEAF + cyc - 1));
        check($sformatf("fetch%0d_out_valid", cyc), 64'(out_valid), 64'd0);
        check($sformatf("fetch%0d_in_ready", cyc), 64'(in_ready), 64'd0);
      end else if (cyc < LEAF + 4) begin
        check($sformatf("drain%0d_ren", cyc), 64'(mem_ren), 64'd0);
        check($sformatf("drain%0d_out_valid", cyc), 64'(out_valid), 64'd0);
        check($sformatf("drain%0d_in_ready", cyc), 64'(in_ready), 64'd0);
      end else begin
        check($sformatf("done%0d_out_valid", cyc), 64'(out_valid), 64'd1);
        check($sformatf("done%0d_index", cyc), 64'(best_index), 64'(exp_idx));
        check($sformatf("done%0d_dist", cyc), 64'(best_dist), 64'(exp_dist));
        check($sformatf("done%0d_in_ready", cyc), 64'(in_ready), 64'd0);
        check($sformatf("done%0d_ren", cyc), 64'(mem_ren), 64'd0);
      end
      cyc++;
    end
  end

  // Run one query starting at the current cycle, which must be IDLE. Hold
  // the result for 'hold' extra cycles, then release it.
  task automatic run_query(input string tag, input logic [PW-1:0] q, input logic [7:0] leaf,
                           input int hold, input bit spurious, input bit use_lit,
                           input logic [IW-1:0] lit_idx, input logic [DW-1:0] lit_dist);
    logic [IW-1:0] mi;
    logic [DW-1:0] md;
    model(q, int'(leaf), mi, md);
    if (use_lit) begin
      check({tag, "_model_idx"}, 64'(mi), 64'(lit_idx));
      check({tag, "_model_dist"}, 64'(md), 64'(lit_dist));
    end
    exp_leaf   = int'(leaf);
    exp_idx    = mi;
    exp_dist   = md;
    patch_in   = q;
    leaf_index = leaf;
    in_valid   = 1'b1;
    track      = 1'b1;
    @(posedge clk); #1;                 // cycle 1
    in_valid   = 1'b0;
    patch_in   = {$urandom, $urandom};  // later changes must not matter
    leaf_index = ~leaf;
    repeat (LEAF + 3) @(posedge clk);
    #1;                                 // cycle LEAF+4: result expected
    @(negedge clk);
    if (use_lit) begin
      check({tag, "_dut_idx"}, 64'(best_index), 64'(lit_idx));
      check({tag, "_dut_dist"}, 64'(best_dist), 64'(lit_dist));
    end
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (spurious) begin
        in_valid   = 1'b1;
        leaf_index = 8'd5;
        patch_in   = {$urandom, $urandom};
      end
    end
    @(posedge clk); #1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;                 // back in IDLE
    out_ready = 1'b0;
    track     = 1'b0;
    @(negedge clk);
    check({tag, "_idle_in_ready"}, 64'(in_ready), 64'd1);
    check({tag, "_idle_out_valid"}, 64'(out_valid), 64'd0);
    check({tag, "_idle_ren"}, 64'(mem_ren), 64'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst        = 1'b1;
    in_valid   = 1'b0;
    out_ready  = 1'b0;
    patch_in   = '0;
    leaf_index = '0;

    // Test 1 data: leaf 3, slot s = s+1 everywhere, idx 100+s.
    for (int s = 0; s < LEAF; s++) put(3, s, 16'(100 + s), fill(s + 1));
    // Test 2 data: leaf 7, slot s = s, idx s.
    for (int s = 0; s < LEAF; s++) put(7, s, 16'(s), fill(s));
    // Test 3 data: leaf 10, two ties at distance 1 in slots 2 and 5.
    for (int s = 0; s < LEAF; s++) put(10, s, 16'h1000 + 16'(s), fill(3));
    put(10, 2, 16'h0202, {fill(0)[PW-1:D], 11'd1});
    put(10, 5, 16'h0505, {fill(0)[PW-1:4*D], 11'h7FF, fill(0)[3*D-1:0]});
    // Test 4 data: leaf 20 has empty slots 0 and 1 that would otherwise be exact.
    for (int s = 0; s < LEAF; s++) put(20, s, 16'h0100 + 16'(s), fill(10));
    put(20, 0, 16'hFFFF, fill(-5));
    put(20, 1, 16'hFFFF, fill(-5));
    put(20, 6, 16'h0606, fill(-4));
    // Leaf 21 is entirely empty.
    for (int s = 0; s < LEAF; s++) put(21, s, 16'hFFFF, fill(-5));
    // Test 5 data: leaf 255 has a single full-scale candidate in slot 4.
    for (int s = 0; s < LEAF; s++) put(255, s, 16'hFFFF, fill(0));
    put(255, 4, 16'h1234, fill(1023));
    // Test 6 data: leaf 40 is all exact (aborted query); leaf 41 has the nearest in slot 7.
    for (int s = 0; s < LEAF; s++) put(40, s, 16'h0040 + 16'(s), fill(0));
    for (int s = 0; s < LEAF; s++) put(41, s, 16'h4100 + 16'(s), fill(2));
    put(41, 7, 16'h4107, fill(1));

    // Reset values.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 64'(in_ready), 64'd0);
    check("rst_mem_ren", 64'(mem_ren), 64'd0);
    check("rst_mem_addr", 64'(mem_addr), 64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_best_index", 64'(best_index), 64'hFFFF);
    check("rst_best_dist", 64'(best_dist), 64'h3FFFFFF);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;

    run_query("t1", fill(0), 8'd3, 0, 1'b0, 1'b1, 16'd100, 26'd5);
    run_query("t2", fill(4), 8'd7, 2, 1'b0, 1'b1, 16'd4, 26'd0);
    run_query("t3_tie", fill(0), 8'd10, 0, 1'b0, 1'b1, 16'h0202, 26'd1);
    run_query("t4_empty", fill(-5), 8'd20, 0, 1'b0, 1'b1, 16'h0606, 26'd5);
    run_query("t4_all_empty", fill(-5), 8'd21, 0, 1'b0, 1'b1, 16'hFFFF, 26'h3FFFFFF);
    // 5 * 2047^2 = 20951045
    run_query("t5_extreme", fill(-1024), 8'd255, 10, 1'b1, 1'b1, 16'h1234, 26'd20951045);

    // Test 6: reset arrives in cycle 4 of a query on leaf 40.
    exp_leaf   = 40;
    exp_idx    = 16'h0040;
    exp_dist   = '0;
    patch_in   = fill(0);
    leaf_index = 8'd40;
    in_valid   = 1'b1;
    track      = 1'b1;
    @(posedge clk); #1;
    in_valid   = 1'b0;
    repeat (3) @(posedge clk);
    #1;                                 // cycle 4
    rst   = 1'b1;
    track = 1'b0;
    @(negedge clk);
    check("t6_rst_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;                 // cycle 5
    @(negedge clk);
    check("t6_ren_after_rst", 64'(mem_ren), 64'd0);
    check("t6_addr_after_rst", 64'(mem_addr), 64'd0);
    check("t6_out_valid_after_rst", 64'(out_valid), 64'd0);
    check("t6_index_after_rst", 64'(best_index), 64'hFFFF);
    check("t6_dist_after_rst", 64'(best_dist), 64'h3FFFFFF);
    @(posedge clk); #1;                 // cycle 6
    rst = 1'b0;
    run_query("t6_after_rst", fill(0), 8'd41, 0, 1'b0, 1'b1, 16'h4107, 26'd5);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
